// File: rtl/wb_mprj_xbar.sv
`default_nettype none
// ============================================================================
// Module   : wb_mprj_xbar
// Purpose  : Wishbone slave-side decoder/bridge that routes Caravel user-area
//            transfers to NUM_SLV targets, with timeout and error reporting.
// Revision : 1.0
// ============================================================================
module wb_mprj_xbar #(
    parameter int unsigned      NUM_SLV   = 4,
    parameter int unsigned      AW        = 32,
    parameter int unsigned      DW        = 32,
    parameter int unsigned      SEL_LSB   = 20,
    parameter int unsigned      IDX_W     = 2,
    parameter logic [AW-1:0]    BASE_ADDR = 32'h3000_0000,
    parameter int unsigned      TIMEOUT   = 255,
    parameter logic [DW-1:0]    ERR_DATA  = 32'hBADC_AB1E
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [DW/8-1:0]       wbs_sel_i,
    input  logic [AW-1:0]         wbs_adr_i,
    input  logic [DW-1:0]         wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic [DW-1:0]         wbs_dat_o,
    output logic [NUM_SLV-1:0]    m_stb_o,
    output logic                  m_we_o,
    output logic [DW/8-1:0]       m_sel_o,
    output logic [AW-1:0]         m_adr_o,
    output logic [DW-1:0]         m_dat_o,
    input  logic [NUM_SLV-1:0]    m_ack_i,
    input  logic [NUM_SLV*DW-1:0] m_dat_i,
    output logic                  err_irq_o,
    output logic [7:0]            err_cnt_o
);

    localparam int unsigned   CNT_W      = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    wait_cnt_q;
    logic                ack_q;
    logic [DW-1:0]       dat_q;
    logic [NUM_SLV-1:0]  m_stb_q;
    logic                m_we_q;
    logic [DW/8-1:0]     m_sel_q;
    logic [AW-1:0]       m_adr_q;
    logic [DW-1:0]       m_dat_q;
    logic                irq_q;
    logic [7:0]          err_cnt_q;

    logic [IDX_W-1:0]    w_idx;
    logic                w_hi_ok;
    logic                w_idx_ok;
    logic                w_dec_err;
    logic [NUM_SLV-1:0]  w_onehot;
    logic                w_ack;
    logic [DW-1:0]       w_rdat;

    // Bits above the index field must equal the window base.
    assign w_idx     = wbs_adr_i[SEL_LSB +: IDX_W];
    assign w_hi_ok   = ((wbs_adr_i ^ BASE_ADDR) >> (SEL_LSB + IDX_W)) == '0;
    assign w_idx_ok  = 32'(w_idx) < NUM_SLV;
    assign w_dec_err = !(w_hi_ok && w_idx_ok);
    assign w_onehot  = NUM_SLV'(1) << w_idx;

    // Masking with the active strobe ignores acks from unselected targets.
    assign w_ack = |(m_ack_i & m_stb_q);

    always_comb begin
        w_rdat = '0;
        for (int i = 0; i < int'(NUM_SLV); i++) begin
            if (m_stb_q[i]) begin
                w_rdat = w_rdat | m_dat_i[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            m_stb_q    <= '0;
            m_we_q     <= 1'b0;
            m_sel_q    <= '0;
            m_adr_q    <= '0;
            m_dat_q    <= '0;
            irq_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            ack_q <= 1'b0;
            irq_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (wbs_cyc_i && wbs_stb_i) begin
                        m_we_q     <= wbs_we_i;
                        m_sel_q    <= wbs_sel_i;
                        m_adr_q    <= wbs_adr_i;
                        m_dat_q    <= wbs_dat_i;
                        wait_cnt_q <= '0;
                        if (w_dec_err) begin
                            state_q <= ST_RESP;
                            ack_q   <= 1'b1;
                            dat_q   <= ERR_DATA;
                            irq_q   <= 1'b1;
                            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                        end else begin
                            state_q <= ST_REQ;
                            m_stb_q <= w_onehot;
                        end
                    end
                end
                ST_REQ: begin
                    if (!wbs_cyc_i) begin
                        m_stb_q <= '0;
                        state_q <= ST_IDLE;
                    end else if (w_ack) begin
                        m_stb_q <= '0;
                        dat_q   <= m_we_q ? '0 : w_rdat;
                        ack_q   <= 1'b1;
                        state_q <= ST_RESP;
                    end else if (wait_cnt_q == CNT_LAST) begin
                        m_stb_q <= '0;
                        dat_q   <= ERR_DATA;
                        ack_q   <= 1'b1;
                        irq_q   <= 1'b1;
                        state_q <= ST_RESP;
                        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign m_stb_o   = m_stb_q;
    assign m_we_o    = m_we_q;
    assign m_sel_o   = m_sel_q;
    assign m_adr_o   = m_adr_q;
    assign m_dat_o   = m_dat_q;
    assign err_irq_o = irq_q;
    assign err_cnt_o = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_mprj_xbar.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_mprj_xbar
// Purpose  : Directed self-checking bench for wb_mprj_xbar.
// Revision : 1.0
// ============================================================================
module tb_wb_mprj_xbar;

    logic         clk;
    logic         rst_n;
    logic         cyc, stb, we;
    logic [3:0]   sel;
    logic [31:0]  adr, wdat;
    logic         ack;
    logic [31:0]  rdat;
    logic [3:0]   m_stb;
    logic         m_we;
    logic [3:0]   m_sel;
    logic [31:0]  m_adr, m_wdat;
    logic [3:0]   m_ack;
    logic [127:0] m_rdat;
    logic         irq;
    logic [7:0]   ecnt;

    int total = 0;
    int bad   = 0;

    wb_mprj_xbar dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat),
        .m_stb_o   (m_stb),
        .m_we_o    (m_we),
        .m_sel_o   (m_sel),
        .m_adr_o   (m_adr),
        .m_dat_o   (m_wdat),
        .m_ack_i   (m_ack),
        .m_dat_i   (m_rdat),
        .err_irq_o (irq),
        .err_cnt_o (ecnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    endtask

    task automatic idle_bus();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; m_ack = '0;
    endtask

    initial begin
        int  n;
        bit  seen;

        rst_n = 1'b0; m_ack = '0; m_rdat = '0;
        req(1'b0, 32'h3010_0004, 32'h0, 4'hF);
        tick(); tick(); tick();
        chk("rst_ack",  ack,   1'b0);
        chk("rst_stb",  m_stb, 4'b0000);
        chk("rst_irq",  irq,   1'b0);
        chk("rst_ecnt", ecnt,  8'h00);
        idle_bus();
        rst_n = 1'b1;
        tick();

        // Read target 1, combinational ack on the first strobe cycle.
        req(1'b0, 32'h3010_0004, 32'h0, 4'hF);
        tick();
        chk("rd_stb",   m_stb, 4'b0010);
        chk("rd_ack0",  ack,   1'b0);
        chk("rd_adr",   m_adr, 32'h3010_0004);
        m_ack = 4'b0010; m_rdat[32 +: 32] = 32'h1234_5678;
        tick();
        chk("rd_ack",   ack,   1'b1);
        chk("rd_dat",   rdat,  32'h1234_5678);
        chk("rd_irq",   irq,   1'b0);
        chk("rd_stbdn", m_stb, 4'b0000);
        idle_bus();
        tick();
        chk("rd_ackpulse", ack, 1'b0);

        // Write target 3; a stray ack from target 0 must be ignored.
        req(1'b1, 32'h3030_0000, 32'hA5A5_A5A5, 4'hF);
        tick();
        chk("wr_stb",  m_stb,  4'b1000);
        chk("wr_dat",  m_wdat, 32'hA5A5_A5A5);
        chk("wr_we",   m_we,   1'b1);
        chk("wr_sel",  m_sel,  4'hF);
        m_ack = 4'b0001;
        tick();
        chk("wr_stray", ack,   1'b0);
        chk("wr_hold",  m_stb, 4'b1000);
        m_ack = 4'b1000; m_rdat[96 +: 32] = 32'hDEAD_BEEF;
        tick();
        chk("wr_ack",  ack,  1'b1);
        chk("wr_rdat", rdat, 32'h0);
        idle_bus();
        tick();

        // Decode error outside the window.
        req(1'b0, 32'h4000_0000, 32'h0, 4'hF);
        tick();
        chk("de_ack",  ack,   1'b1);
        chk("de_dat",  rdat,  32'hBADC_AB1E);
        chk("de_irq",  irq,   1'b1);
        chk("de_ecnt", ecnt,  8'h01);
        chk("de_stb",  m_stb, 4'b0000);
        idle_bus();
        tick();
        chk("de_irqdn", irq, 1'b0);

        // Timeout: target 2 never acks.
        req(1'b0, 32'h3020_0000, 32'h0, 4'hF);
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) chk("to_stb", m_stb, 4'b0100);
        end while (!ack && n < 400);
        chk("to_lat",  n,     256);
        chk("to_dat",  rdat,  32'hBADC_AB1E);
        chk("to_irq",  irq,   1'b1);
        chk("to_stb0", m_stb, 4'b0000);
        chk("to_ecnt", ecnt,  8'h02);
        idle_bus();
        tick();

        // Ack on the 255th strobe cycle coincides with the timeout: ack wins.
        req(1'b0, 32'h3020_0000, 32'h0, 4'hF);
        seen = 1'b0;
        for (int k = 1; k <= 255; k++) begin
            tick();
            if (ack) seen = 1'b1;
        end
        chk("race_early", seen, 1'b0);
        m_ack = 4'b0100; m_rdat[64 +: 32] = 32'h0BAD_F00D;
        tick();
        chk("race_ack",  ack,  1'b1);
        chk("race_dat",  rdat, 32'h0BAD_F00D);
        chk("race_irq",  irq,  1'b0);
        chk("race_ecnt", ecnt, 8'h02);
        idle_bus();
        tick();

        // Master abort during REQ.
        req(1'b0, 32'h3000_0000, 32'h0, 4'hF);
        tick();
        chk("ab_stb", m_stb, 4'b0001);
        tick();
        cyc = 1'b0; stb = 1'b0;
        tick();
        chk("ab_stbdn", m_stb, 4'b0000);
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (ack || irq) seen = 1'b1;
            tick();
        end
        chk("ab_noack", seen, 1'b0);
        chk("ab_ecnt",  ecnt, 8'h02);
        req(1'b0, 32'h3000_0000, 32'h0, 4'hF);
        m_ack = 4'b0001; m_rdat[0 +: 32] = 32'h5555_AAAA;
        tick(); tick();
        chk("ab_next", rdat, 32'h5555_AAAA);
        chk("ab_nack", ack,  1'b1);
        idle_bus();
        tick();

        // Request held through RESP is not re-sampled until the cycle after ack.
        req(1'b0, 32'h3100_0000, 32'h0, 4'hF);
        tick();
        chk("b2b_ack1", ack, 1'b1);
        tick();
        chk("b2b_gap",  ack, 1'b0);
        tick();
        chk("b2b_ack2", ack, 1'b1);
        chk("b2b_ecnt", ecnt, 8'h04);
        idle_bus();
        tick();

        // Saturation of the error counter.
        for (int k = 0; k < 300; k++) begin
            req(1'b0, 32'h5000_0000, 32'h0, 4'hF);
            tick();
            idle_bus();
            tick();
        end
        chk("sat_ecnt", ecnt, 8'hFF);

        // Reset mid-transfer aborts with no ack.
        req(1'b0, 32'h3010_0000, 32'h0, 4'hF);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_stb",  m_stb, 4'b0000);
        chk("mrst_ecnt", ecnt,  8'h00);
        idle_bus();
        tick();
        chk("mrst_ack", ack, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
